// File: rtl/reg_wb_arbiter_if.sv
// Writeback bus between the ALU/MEM requesters, the issue stage and the arbiter.
// The arbiter takes the slave modport; the requesters and the issue stage take the master modport.
interface reg_wb_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        mem_valid;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;

  logic        claim_en;
  logic [4:0]  claim_reg;
  logic [4:0]  query_reg1;
  logic [4:0]  query_reg2;
  logic        busy1;
  logic        busy2;

  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    output alu_ready,
    input  mem_valid, mem_reg, mem_data,
    output mem_ready,
    input  claim_en, claim_reg, query_reg1, query_reg2,
    output busy1, busy2,
    output reg_write, write_reg, write_data
  );

  modport master (
    output alu_valid, alu_reg, alu_data,
    input  alu_ready,
    output mem_valid, mem_reg, mem_data,
    input  mem_ready,
    output claim_en, claim_reg, query_reg1, query_reg2,
    input  busy1, busy2,
    input  reg_write, write_reg, write_data
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: MEM has priority, ALU wins after STARVE_LIMIT stalls.
// Also tracks which destination registers have a write still in flight (busy bitmap).
module reg_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            rst,
  reg_wb_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt;
  logic [31:0] busy_map;
  logic [31:0] busy_next;
  logic        alu_override;
  logic        alu_grant;
  logic        mem_grant;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;

  // Grant depends only on the valids and the stall counter, never on ready.
  always_comb begin
    alu_override = bus.alu_valid && (starve_cnt == LIMIT);
    alu_grant    = !rst && bus.alu_valid && (!bus.mem_valid || alu_override);
    mem_grant    = !rst && bus.mem_valid && !alu_override;
  end

  assign bus.alu_ready = alu_grant;
  assign bus.mem_ready = mem_grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!bus.alu_valid || alu_grant) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Writes to r0 are accepted on the bus but never reach the register file.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_reg  <= 5'd0;
      wr_data <= 32'd0;
    end else if (alu_grant) begin
      wr_en   <= (bus.alu_reg != 5'd0);
      wr_reg  <= bus.alu_reg;
      wr_data <= bus.alu_data;
    end else if (mem_grant) begin
      wr_en   <= (bus.mem_reg != 5'd0);
      wr_reg  <= bus.mem_reg;
      wr_data <= bus.mem_data;
    end else begin
      wr_en   <= 1'b0;
    end
  end

  assign bus.reg_write  = wr_en;
  assign bus.write_reg  = wr_reg;
  assign bus.write_data = wr_data;

  // Claim is applied after clear so a same-edge claim of the retiring register wins.
  always_comb begin
    busy_next = busy_map;
    if (wr_en) begin
      busy_next[wr_reg] = 1'b0;
    end
    if (bus.claim_en && (bus.claim_reg != 5'd0)) begin
      busy_next[bus.claim_reg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_map <= 32'd0;
    end else begin
      busy_map <= busy_next;
    end
  end

  assign bus.busy1 = busy_map[bus.query_reg1];
  assign bus.busy2 = busy_map[bus.query_reg2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed and random checks for the writeback arbiter and its busy bitmap.
// Inputs change 1ns after posedge; outputs are sampled on the following negedge.
module tb_reg_wb_arbiter;

  localparam int LIMIT = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  reg_wb_arbiter_if bus();

  reg_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.alu_valid  = 1'b0;
    bus.alu_reg    = 5'd0;
    bus.alu_data   = 32'd0;
    bus.mem_valid  = 1'b0;
    bus.mem_reg    = 5'd0;
    bus.mem_data   = 32'd0;
    bus.claim_en   = 1'b0;
    bus.claim_reg  = 5'd0;
    bus.query_reg1 = 5'd0;
    bus.query_reg2 = 5'd0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic        exp_a;
  logic        exp_m;
  logic        exp_we;
  logic [4:0]  exp_wreg;
  logic [31:0] exp_wdata;
  logic [31:0] bm_m;
  int          stall_m;
  int          wait_m;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.mem_valid = 1'b1;
    bus.mem_reg   = 5'd4;
    rst = 1'b1;
    sample();
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    step();
    idle_inputs();
    step();
    rst = 1'b0;
    sample();
    chk("post_rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("post_rst_write_reg", 32'(bus.write_reg), 32'd0);
    chk("post_rst_write_data", bus.write_data, 32'd0);
    chk("post_rst_busy1", 32'(bus.busy1), 32'd0);
    chk("post_rst_busy2", 32'(bus.busy2), 32'd0);

    // Starvation override: MEM wins three cycles, ALU the fourth.
    step();
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd3; bus.alu_data = 32'h11;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd5; bus.mem_data = 32'h22;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("starve_mem_ready_c%0d", i), 32'(bus.mem_ready), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("starve_alu_ready_c%0d", i), 32'(bus.alu_ready), (i < 3) ? 32'd0 : 32'd1);
      if (i > 0) chk($sformatf("starve_write_reg_c%0d", i), 32'(bus.write_reg), 32'd5);
      step();
    end
    idle_inputs();
    sample();
    chk("starve_c4_reg_write", 32'(bus.reg_write), 32'd1);
    chk("starve_c4_write_reg", 32'(bus.write_reg), 32'd3);
    chk("starve_c4_write_data", bus.write_data, 32'h11);
    step();
    sample();
    chk("starve_c5_reg_write", 32'(bus.reg_write), 32'd0);
    chk("starve_c5_hold_reg", 32'(bus.write_reg), 32'd3);
    chk("starve_c5_hold_data", bus.write_data, 32'h11);

    // Claim r7, then a MEM write to r7 clears it two cycles after the handshake.
    step();
    bus.claim_en = 1'b1; bus.claim_reg = 5'd7; bus.query_reg1 = 5'd7;
    sample();
    chk("claim7_no_bypass", 32'(bus.busy1), 32'd0);
    step();
    bus.claim_en = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd7; bus.mem_data = 32'h77;
    sample();
    chk("clr7_mem_ready", 32'(bus.mem_ready), 32'd1);
    chk("clr7_busy_n", 32'(bus.busy1), 32'd1);
    step();
    bus.mem_valid = 1'b0;
    sample();
    chk("clr7_reg_write", 32'(bus.reg_write), 32'd1);
    chk("clr7_busy_n1", 32'(bus.busy1), 32'd1);
    step();
    sample();
    chk("clr7_busy_n2", 32'(bus.busy1), 32'd0);

    // ALU write to r0 is accepted and dropped.
    step();
    bus.claim_en = 1'b1; bus.claim_reg = 5'd2; bus.query_reg2 = 5'd2;
    step();
    bus.claim_en = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd0; bus.alu_data = 32'hDEAD;
    sample();
    chk("r0_alu_ready", 32'(bus.alu_ready), 32'd1);
    step();
    bus.alu_valid = 1'b0;
    sample();
    chk("r0_reg_write", 32'(bus.reg_write), 32'd0);
    chk("r0_write_data", bus.write_data, 32'hDEAD);
    step();
    sample();
    chk("r0_busy2_kept", 32'(bus.busy2), 32'd1);

    // Same-edge claim and clear of r9: claim wins.
    step();
    bus.claim_en = 1'b1; bus.claim_reg = 5'd9; bus.query_reg1 = 5'd9;
    step();
    bus.claim_en = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd9; bus.mem_data = 32'h99;
    sample();
    chk("r9_busy_before", 32'(bus.busy1), 32'd1);
    step();
    bus.mem_valid = 1'b0;
    bus.claim_en = 1'b1; bus.claim_reg = 5'd9;
    sample();
    chk("r9_reg_write", 32'(bus.reg_write), 32'd1);
    chk("r9_write_reg", 32'(bus.write_reg), 32'd9);
    step();
    bus.claim_en = 1'b0;
    sample();
    chk("r9_claim_wins", 32'(bus.busy1), 32'd1);

    // Fill the bitmap, then reset with a MEM request pending.
    for (int k = 0; k < 32; k++) begin
      step();
      bus.claim_en = 1'b1; bus.claim_reg = 5'(k);
    end
    step();
    bus.claim_en = 1'b0;
    bus.query_reg1 = 5'd0; bus.query_reg2 = 5'd31;
    sample();
    chk("full_busy_r0", 32'(bus.busy1), 32'd0);
    chk("full_busy_r31", 32'(bus.busy2), 32'd1);
    step();
    bus.query_reg1 = 5'd12;
    sample();
    chk("full_busy_r12", 32'(bus.busy1), 32'd1);
    step();
    rst = 1'b1;
    bus.mem_valid = 1'b1; bus.mem_reg = 5'd12; bus.mem_data = 32'hC;
    bus.alu_valid = 1'b1; bus.alu_reg = 5'd13; bus.alu_data = 32'hD;
    for (int i = 0; i < 2; i++) begin
      sample();
      chk($sformatf("midrst_mem_ready_%0d", i), 32'(bus.mem_ready), 32'd0);
      chk($sformatf("midrst_alu_ready_%0d", i), 32'(bus.alu_ready), 32'd0);
      step();
    end
    rst = 1'b0;
    bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
    sample();
    chk("midrst_after_reg_write", 32'(bus.reg_write), 32'd0);
    chk("midrst_after_busy1", 32'(bus.busy1), 32'd0);
    chk("midrst_after_busy2", 32'(bus.busy2), 32'd0);
    step();
    sample();
    chk("midrst_after2_reg_write", 32'(bus.reg_write), 32'd0);

    // Random traffic with a bench-side arbitration, write and bitmap model.
    idle_inputs();
    do_reset();
    bm_m = 32'd0; exp_we = 1'b0; exp_wreg = 5'd0; exp_wdata = 32'd0;
    stall_m = 0; wait_m = 0;
    for (int c = 0; c < 400; c++) begin
      sample();
      exp_a = bus.alu_valid && (!bus.mem_valid || stall_m == LIMIT);
      exp_m = bus.mem_valid && !exp_a;
      chk("rnd_double_grant", 32'(bus.alu_ready && bus.mem_ready), 32'd0);
      chk("rnd_alu_ready", 32'(bus.alu_ready), 32'(exp_a));
      chk("rnd_mem_ready", 32'(bus.mem_ready), 32'(exp_m));
      chk("rnd_reg_write", 32'(bus.reg_write), 32'(exp_we));
      if (exp_we) begin
        chk("rnd_write_reg", 32'(bus.write_reg), 32'(exp_wreg));
        chk("rnd_write_data", bus.write_data, exp_wdata);
      end
      chk("rnd_busy1", 32'(bus.busy1), 32'(bm_m[bus.query_reg1]));
      chk("rnd_busy2", 32'(bus.busy2), 32'(bm_m[bus.query_reg2]));
      if (bus.alu_ready) chk("rnd_alu_wait_exceeded", 32'(wait_m + 1 > LIMIT + 1), 32'd0);

      if (exp_we) bm_m[exp_wreg] = 1'b0;
      if (bus.claim_en && bus.claim_reg != 5'd0) bm_m[bus.claim_reg] = 1'b1;
      if (exp_a) begin
        exp_we = (bus.alu_reg != 5'd0); exp_wreg = bus.alu_reg; exp_wdata = bus.alu_data;
      end else if (exp_m) begin
        exp_we = (bus.mem_reg != 5'd0); exp_wreg = bus.mem_reg; exp_wdata = bus.mem_data;
      end else begin
        exp_we = 1'b0;
      end
      if (bus.alu_valid && !exp_a) begin
        stall_m = (stall_m < LIMIT) ? stall_m + 1 : LIMIT;
        wait_m++;
      end else begin
        stall_m = 0;
        wait_m = 0;
      end

      step();
      if (!bus.alu_valid || exp_a) begin
        bus.alu_valid = ($urandom_range(0, 3) != 0);
        bus.alu_reg   = 5'($urandom_range(0, 31));
        bus.alu_data  = $urandom;
      end
      if (!bus.mem_valid || exp_m) begin
        bus.mem_valid = ($urandom_range(0, 2) != 0);
        bus.mem_reg   = 5'($urandom_range(0, 31));
        bus.mem_data  = $urandom;
      end
      bus.claim_en   = ($urandom_range(0, 1) != 0);
      bus.claim_reg  = 5'($urandom_range(0, 31));
      bus.query_reg1 = 5'($urandom_range(0, 31));
      bus.query_reg2 = 5'($urandom_range(0, 31));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
